// File: rtl/rf_wb_arbiter_if.sv
// Write-back request bundle: NUM_REQ requesters
// presenting valid/addr/data, arbiter returning ready.
interface rf_wb_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int AW      = 5,
  parameter int DW      = 32
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*AW-1:0] req_addr;
  logic [NUM_REQ*DW-1:0] req_data;

  modport master (
    output req_valid,
    output req_addr,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  req_data,
    output req_ready
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Register-file write-back arbiter: round-robin grant,
// registered write port, pending-write scoreboard.
module rf_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int AW      = 5,
  parameter int DW      = 32
) (
  input  logic              clk,
  input  logic              reset,
  rf_wb_arbiter_if.slave    bus,
  output logic              rf_wr_en,
  output logic [AW-1:0]     rf_wr_addr,
  output logic [DW-1:0]     rf_wr_data,
  input  logic              sb_set_en,
  input  logic [AW-1:0]     sb_set_addr,
  input  logic [AW-1:0]     rs_query,
  input  logic [AW-1:0]     rt_query,
  output logic              rs_busy,
  output logic              rt_busy,
  output logic [2**AW-1:0]  busy_vec
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int NR = 2**AW;

  logic [PW-1:0]      rr_ptr;
  logic [PW-1:0]      rr_nxt;
  logic [PW-1:0]      gnt_idx;
  logic [NUM_REQ-1:0] gnt;
  logic               found;
  logic               hs;
  logic [AW-1:0]      sel_addr;
  logic [DW-1:0]      sel_data;
  logic [NR-1:0]      busy_q;
  logic [NR-1:0]      busy_d;
  logic [NR-1:0]      set_m;
  logic [NR-1:0]      clr_m;

  // Scan from rr_ptr upward (wrapping); first valid requester wins
  always_comb begin
    int idx;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && bus.req_valid[idx]) begin
        found     = 1'b1;
        gnt[idx]  = 1'b1;
        gnt_idx   = PW'(idx);
      end
    end
  end

  assign bus.req_ready = reset ? '0 : gnt;
  assign hs            = found & ~reset;
  assign sel_addr      = bus.req_addr[gnt_idx*AW +: AW];
  assign sel_data      = bus.req_data[gnt_idx*DW +: DW];

  // Pointer moves just past the winner so it gets lowest priority next
  always_comb begin
    rr_nxt = rr_ptr;
    if (hs) begin
      if (gnt_idx == PW'(NUM_REQ - 1)) rr_nxt = '0;
      else                             rr_nxt = gnt_idx + PW'(1);
    end
  end

  // Round-robin pointer register
  always_ff @(posedge clk) begin
    if (reset) rr_ptr <= '0;
    else       rr_ptr <= rr_nxt;
  end

  // Registered write port; r0 writes are accepted but never reach the file
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_wr_en   <= 1'b0;
      rf_wr_addr <= '0;
      rf_wr_data <= '0;
    end else begin
      rf_wr_en <= hs & (sel_addr != '0);
      if (hs) begin
        rf_wr_addr <= sel_addr;
        rf_wr_data <= sel_data;
      end
    end
  end

  // Scoreboard next state: set beats clear, bit 0 never pending
  always_comb begin
    set_m  = '0;
    clr_m  = '0;
    if (sb_set_en) set_m[sb_set_addr] = 1'b1;
    if (rf_wr_en)  clr_m[rf_wr_addr]  = 1'b1;
    busy_d    = (busy_q & ~clr_m) | set_m;
    busy_d[0] = 1'b0;
  end

  // Scoreboard register
  always_ff @(posedge clk) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  assign busy_vec = busy_q;
  assign rs_busy  = busy_q[rs_query];
  assign rt_busy  = busy_q[rt_query];

endmodule
